// File: rtl/lcd_fb_rd_sched.sv
// lcd_fb_rd_sched
//   Frame-buffer read scheduler for the LCD output path. It issues burst read
//   requests to the SDRAM controller so the display line FIFO is refilled
//   ahead of the LCD driver. It also owns the double-buffer bank selection
//   between the camera write side and the LCD read side.
//
// Ports
//   sys_clk, sys_rst_n      clock (rising edge), asynchronous active-low reset
//   frame_start             1-cycle vsync pulse, already in the sys_clk domain
//   h_disp, v_disp          active pixels per line / active lines per frame
//   fifo_wr_cnt             line FIFO fill level in words
//   fifo_flush              1-cycle pulse that clears the line FIFO at frame start
//   rd_req/rd_addr/rd_len   burst request; held, with stable address and length,
//                           until rd_ack
//   rd_ack, rd_done         controller accept / last word of the burst written
//   wr_bank_done            camera finished a frame in wr_bank
//   wr_bank, rd_bank        camera bank / displayed bank (always complementary)
//   busy                    frame read in progress
//   frame_late              frame_start arrived before the frame was fully read
module lcd_fb_rd_sched #(
  parameter int                ADDR_W     = 24,
  parameter int                BURST_LEN  = 64,
  parameter int                FIFO_DEPTH = 1024,
  parameter int                CNT_W      = 11,
  parameter logic [ADDR_W-1:0] FB0_BASE   = 24'h000000,
  parameter logic [ADDR_W-1:0] FB1_BASE   = 24'h200000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              frame_start,
  input  logic [10:0]       h_disp,
  input  logic [10:0]       v_disp,
  input  logic [CNT_W-1:0]  fifo_wr_cnt,
  output logic              fifo_flush,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_len,
  input  logic              rd_ack,
  input  logic              rd_done,
  input  logic              wr_bank_done,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic              busy,
  output logic              frame_late
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    CHECK,
    REQ,
    WAIT_DONE
  } state_t;

  localparam logic [21:0]  BURST_W = 22'(BURST_LEN);
  localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(FIFO_DEPTH);

  state_t              state;
  state_t              next_state;
  logic [21:0]         remaining;
  logic [ADDR_W-1:0]   offset;
  logic                swap_pend;
  logic                restart_pend;

  logic [21:0]         frame_words;
  logic [21:0]         len_full;
  logic [21:0]         remaining_after;
  logic                fits;
  logic [ADDR_W-1:0]   base;

  // Frame size: 11x11 bits never exceeds 22 bits, so no overflow handling.
  assign frame_words = {11'd0, h_disp} * {11'd0, v_disp};

  // Next burst is the smaller of a full burst and what is left of the frame.
  assign len_full = (remaining < BURST_W) ? remaining : BURST_W;

  // One extra bit on the compare so a nearly full FIFO plus a burst cannot wrap.
  assign fits = (({1'b0, fifo_wr_cnt} + len_full[CNT_W:0]) <= DEPTH_W);

  assign remaining_after = remaining - {14'd0, rd_len};
  assign base            = rd_bank ? FB1_BASE : FB0_BASE;

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and the outputs that follow directly from the state.
  // A restart requested while a burst is in flight waits for that burst's
  // rd_done so only one burst is ever outstanding; a frame_start coinciding
  // with rd_done restarts immediately.
  always_comb begin
    next_state = state;
    fifo_flush = 1'b0;
    rd_req     = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) next_state = START;
      end
      START: begin
        fifo_flush = 1'b1;
        busy       = (frame_words != 22'd0);
        next_state = (frame_words == 22'd0) ? IDLE : CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        if (frame_start) begin
          next_state = START;
        end else if (fits) begin
          next_state = REQ;
        end
      end
      REQ: begin
        busy   = 1'b1;
        rd_req = 1'b1;
        if (rd_ack) next_state = WAIT_DONE;
      end
      WAIT_DONE: begin
        busy = 1'b1;
        if (rd_done) begin
          if (restart_pend || frame_start) begin
            next_state = START;
          end else if (remaining_after != 22'd0) begin
            next_state = CHECK;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: frame progress, burst request fields, bank swap and restart
  // bookkeeping. The bank only toggles in START, so it never changes mid-frame.
  // A wr_bank_done landing in START itself is kept pending for the next frame.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      remaining    <= 22'd0;
      offset       <= '0;
      rd_addr      <= '0;
      rd_len       <= 8'd0;
      rd_bank      <= 1'b0;
      swap_pend    <= 1'b0;
      restart_pend <= 1'b0;
      frame_late   <= 1'b0;
    end else begin
      frame_late <= frame_start && (state != IDLE);

      if (state == START && swap_pend) begin
        rd_bank   <= ~rd_bank;
        swap_pend <= 1'b0;
      end
      if (wr_bank_done) swap_pend <= 1'b1;

      if (state == WAIT_DONE && rd_done) begin
        restart_pend <= 1'b0;
      end else if ((state == REQ || state == WAIT_DONE) && frame_start) begin
        restart_pend <= 1'b1;
      end

      case (state)
        START: begin
          remaining <= frame_words;
          offset    <= '0;
        end
        CHECK: begin
          if (!frame_start && fits) begin
            rd_addr <= base + offset;
            rd_len  <= len_full[7:0];
          end
        end
        WAIT_DONE: begin
          if (rd_done) begin
            offset    <= offset + {{(ADDR_W - 8){1'b0}}, rd_len};
            remaining <= remaining_after;
          end
        end
        default: ;
      endcase
    end
  end

  assign wr_bank = ~rd_bank;

endmodule

// File: tb/tb_lcd_fb_rd_sched.sv
// tb_lcd_fb_rd_sched
//   Directed bench for lcd_fb_rd_sched. The controller side (rd_ack/rd_done)
//   is played by tasks; expected burst addresses and lengths are hand-computed
//   from the frame size, bank base and burst length.
module tb_lcd_fb_rd_sched;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        frame_start;
  logic [10:0] h_disp;
  logic [10:0] v_disp;
  logic [10:0] fifo_wr_cnt;
  logic        fifo_flush;
  logic        rd_req;
  logic [23:0] rd_addr;
  logic [7:0]  rd_len;
  logic        rd_ack;
  logic        rd_done;
  logic        wr_bank_done;
  logic        wr_bank;
  logic        rd_bank;
  logic        busy;
  logic        frame_late;

  int check_count = 0;
  int error_count = 0;

  lcd_fb_rd_sched dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .frame_start  (frame_start),
    .h_disp       (h_disp),
    .v_disp       (v_disp),
    .fifo_wr_cnt  (fifo_wr_cnt),
    .fifo_flush   (fifo_flush),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_len       (rd_len),
    .rd_ack       (rd_ack),
    .rd_done      (rd_done),
    .wr_bank_done (wr_bank_done),
    .wr_bank      (wr_bank),
    .rd_bank      (rd_bank),
    .busy         (busy),
    .frame_late   (frame_late)
  );

  // 100 MHz system clock.
  always #5 sys_clk = ~sys_clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // One-cycle pulse on frame_start and/or wr_bank_done. On return the bench
  // sits in the cycle after the pulse.
  task automatic applyStimulus(input logic fs, input logic wbd);
    frame_start  = fs;
    wr_bank_done = wbd;
    tick();
    frame_start  = 1'b0;
    wr_bank_done = 1'b0;
  endtask

  // Bounded wait for rd_req; a timeout shows up as a failed check.
  task automatic waitReq(input string tag);
    int waited;
    waited = 0;
    while (rd_req !== 1'b1 && waited < 100) begin
      tick();
      waited++;
    end
    checkOutput({tag, "_req"}, {31'd0, rd_req}, 32'd1);
  endtask

  // Acknowledge the pending request one cycle later, then finish the burst
  // with rd_done 70 cycles after the accept.
  task automatic finishBurst(input string tag);
    tick();
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    checkOutput({tag, "_req_drop"}, {31'd0, rd_req}, 32'd0);
    repeat (69) tick();
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
  endtask

  task automatic serveBurst(input string tag, input logic [23:0] exp_addr,
                            input logic [7:0] exp_len);
    waitReq(tag);
    if (rd_req === 1'b1) begin
      checkOutput({tag, "_addr"}, {8'd0, rd_addr}, {8'd0, exp_addr});
      checkOutput({tag, "_len"}, {24'd0, rd_len}, {24'd0, exp_len});
      finishBurst(tag);
    end
  endtask

  // 4x40 frame = 160 words: bursts of 64, 64 and 32 from the bank base.
  task automatic serveFrame(input string tag, input logic [23:0] base);
    serveBurst({tag, "_b0"}, base, 8'd64);
    serveBurst({tag, "_b1"}, base + 24'd64, 8'd64);
    serveBurst({tag, "_b2"}, base + 24'd128, 8'd32);
    checkOutput({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    sys_rst_n    = 1'b0;
    frame_start  = 1'b0;
    wr_bank_done = 1'b0;
    h_disp       = 11'd4;
    v_disp       = 11'd40;
    fifo_wr_cnt  = 11'd0;
    rd_ack       = 1'b0;
    rd_done      = 1'b0;
    tick();
    tick();

    checkOutput("rst_rd_req", {31'd0, rd_req}, 32'd0);
    checkOutput("rst_rd_addr", {8'd0, rd_addr}, 32'd0);
    checkOutput("rst_rd_len", {24'd0, rd_len}, 32'd0);
    checkOutput("rst_flush", {31'd0, fifo_flush}, 32'd0);
    checkOutput("rst_rd_bank", {31'd0, rd_bank}, 32'd0);
    checkOutput("rst_wr_bank", {31'd0, wr_bank}, 32'd1);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_late", {31'd0, frame_late}, 32'd0);
    sys_rst_n = 1'b1;
    tick();

    // T1: basic frame; flush the cycle after frame_start, rd_req two later.
    $display("[TB] T1 basic frame");
    applyStimulus(1'b1, 1'b0);
    checkOutput("t1_flush", {31'd0, fifo_flush}, 32'd1);
    checkOutput("t1_busy", {31'd0, busy}, 32'd1);
    tick();
    checkOutput("t1_flush_pulse", {31'd0, fifo_flush}, 32'd0);
    checkOutput("t1_req_early", {31'd0, rd_req}, 32'd0);
    tick();
    checkOutput("t1_req_n3", {31'd0, rd_req}, 32'd1);
    checkOutput("t1_late", {31'd0, frame_late}, 32'd0);
    serveFrame("t1", 24'h000000);

    // T2: FIFO too full for a burst holds the scheduler in CHECK.
    $display("[TB] T2 fifo backpressure");
    fifo_wr_cnt = 11'd1000;
    applyStimulus(1'b1, 1'b0);
    repeat (20) tick();
    checkOutput("t2_no_req", {31'd0, rd_req}, 32'd0);
    checkOutput("t2_busy", {31'd0, busy}, 32'd1);
    fifo_wr_cnt = 11'd960;
    checkOutput("t2_req_before", {31'd0, rd_req}, 32'd0);
    tick();
    checkOutput("t2_req_after", {31'd0, rd_req}, 32'd1);
    checkOutput("t2_len", {24'd0, rd_len}, 32'd64);
    serveFrame("t2", 24'h000000);
    fifo_wr_cnt = 11'd0;

    // T3: bank swap on the next frame after wr_bank_done.
    $display("[TB] T3 bank swap");
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t3_bank_hold_start", {31'd0, rd_bank}, 32'd0);
    tick();
    checkOutput("t3_rd_bank", {31'd0, rd_bank}, 32'd1);
    checkOutput("t3_wr_bank", {31'd0, wr_bank}, 32'd0);
    serveFrame("t3a", 24'h200000);
    applyStimulus(1'b1, 1'b0);
    tick();
    checkOutput("t3_bank_kept", {31'd0, rd_bank}, 32'd1);
    serveFrame("t3b", 24'h200000);
    // wr_bank_done together with frame_start swaps for that same frame.
    applyStimulus(1'b1, 1'b1);
    tick();
    checkOutput("t3_coincident_bank", {31'd0, rd_bank}, 32'd0);
    serveFrame("t3c", 24'h000000);

    // T4: frame_start during WAIT_DONE of burst 2 -> late, restart at offset 0.
    $display("[TB] T4 late restart");
    applyStimulus(1'b1, 1'b0);
    serveBurst("t4_b0", 24'h000000, 8'd64);
    waitReq("t4_b1");
    checkOutput("t4_b1_addr", {8'd0, rd_addr}, 32'd64);
    tick();
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    repeat (5) tick();
    applyStimulus(1'b1, 1'b0);
    checkOutput("t4_late", {31'd0, frame_late}, 32'd1);
    checkOutput("t4_no_flush_yet", {31'd0, fifo_flush}, 32'd0);
    tick();
    checkOutput("t4_late_pulse", {31'd0, frame_late}, 32'd0);
    checkOutput("t4_no_req", {31'd0, rd_req}, 32'd0);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    checkOutput("t4_flush", {31'd0, fifo_flush}, 32'd1);
    serveFrame("t4r", 24'h000000);

    // T5: empty frame flushes but never requests or reports busy.
    $display("[TB] T5 empty frame");
    h_disp = 11'd0;
    applyStimulus(1'b1, 1'b0);
    checkOutput("t5_flush", {31'd0, fifo_flush}, 32'd1);
    checkOutput("t5_busy_start", {31'd0, busy}, 32'd0);
    repeat (5) tick();
    checkOutput("t5_no_req", {31'd0, rd_req}, 32'd0);
    checkOutput("t5_busy", {31'd0, busy}, 32'd0);
    h_disp = 11'd4;

    // T6: asynchronous reset while a request is pending.
    $display("[TB] T6 async reset");
    applyStimulus(1'b1, 1'b1);
    waitReq("t6");
    checkOutput("t6_addr_pre", {8'd0, rd_addr}, 32'h200000);
    checkOutput("t6_bank_pre", {31'd0, rd_bank}, 32'd1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    checkOutput("t6_req", {31'd0, rd_req}, 32'd0);
    checkOutput("t6_addr", {8'd0, rd_addr}, 32'd0);
    checkOutput("t6_len", {24'd0, rd_len}, 32'd0);
    checkOutput("t6_rd_bank", {31'd0, rd_bank}, 32'd0);
    checkOutput("t6_wr_bank", {31'd0, wr_bank}, 32'd1);
    checkOutput("t6_busy", {31'd0, busy}, 32'd0);
    tick();
    sys_rst_n = 1'b1;
    repeat (10) tick();
    checkOutput("t6_idle_req", {31'd0, rd_req}, 32'd0);
    checkOutput("t6_idle_busy", {31'd0, busy}, 32'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t6_flush", {31'd0, fifo_flush}, 32'd1);
    serveFrame("t6", 24'h000000);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
